// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display types and channel constants
package display_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_state_e;

    localparam int CH_W_DEFAULT   = 8;
    localparam int NUM_CH_DEFAULT = 3;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

endpackage

// File: rtl/pixel_bank_ram.sv
// rtl/pixel_bank_ram.sv - single pixel bank, one write port and one registered read port
module pixel_bank_ram #(
    parameter int DEPTH  = 10000,
    parameter int IDX_W  = 14,
    parameter int PIX_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // storage array is never cleared; the caller only writes in-range addresses
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // read register holds its value between reads so the pixel output is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_pixel_buffer.sv
// rtl/pingpong_pixel_buffer.sv - two-bank pixel buffer with EMPTY/FULL/READING bank handshake
module pingpong_pixel_buffer
    import display_pkg::*;
#(
    parameter int DEPTH   = 10000,
    parameter int ADDR_W  = 20,
    parameter int CH_W    = CH_W_DEFAULT,
    parameter int NUM_CH  = NUM_CH_DEFAULT,
    parameter int WDATA_W = 32,
    parameter int PIX_W   = CH_W * NUM_CH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [WDATA_W-1:0] wr_data,
    output logic               wr_ready,
    output logic               wr_bank,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_done,
    output logic               rd_ready,
    output logic               rd_bank,
    output logic               rd_valid,
    output logic [PIX_W-1:0]   rd_pixel,
    output logic [1:0]         bank_full,
    output logic               err_addr,
    output logic               err_drop
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    bank_state_e      state_q [2];
    logic             wr_bank_q, rd_bank_q;
    logic             rd_valid_q, rd_sel_q, rd_oor_q;
    logic             err_addr_q, err_drop_q;
    logic [PIX_W-1:0] rdata [2];

    logic wr_in_range, rd_in_range;
    logic wr_accept, wr_complete, rd_accept, rd_release;
    logic unused_wdata;

    // bits of the write bus above one pixel are deliberately discarded
    assign unused_wdata = ^wr_data;

    assign wr_ready    = (state_q[wr_bank_q] == BANK_EMPTY);
    assign rd_ready    = (state_q[rd_bank_q] != BANK_EMPTY);
    assign wr_in_range = (wr_addr < DEPTH_A);
    assign rd_in_range = (rd_addr < DEPTH_A);
    assign wr_accept   = wr_en & wr_ready & wr_in_range;
    assign wr_complete = wr_accept & (wr_addr == LAST_A);
    assign rd_accept   = rd_en & rd_ready;
    assign rd_release  = rd_done & rd_ready;

    // bank state machine, bank pointers, read-side flags and sticky errors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_oor_q   <= 1'b0;
            err_addr_q <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            // reader side acts only on rd_bank; a release wins over FULL->READING
            if (rd_release) begin
                state_q[rd_bank_q] <= BANK_EMPTY;
                rd_bank_q          <= ~rd_bank_q;
            end else if (rd_accept && state_q[rd_bank_q] == BANK_FULL) begin
                state_q[rd_bank_q] <= BANK_READING;
            end
            // writer bank is always EMPTY when it completes, so it never aliases the reader's bank
            if (wr_complete) begin
                state_q[wr_bank_q] <= BANK_FULL;
                wr_bank_q          <= ~wr_bank_q;
            end
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_sel_q <= rd_bank_q;
                rd_oor_q <= ~rd_in_range;
            end
            if ((wr_en && !wr_in_range) || (rd_en && !rd_in_range)) begin
                err_addr_q <= 1'b1;
            end
            if ((wr_en && !wr_ready) || (rd_en && !rd_ready)) begin
                err_drop_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pixel_bank_ram #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W),
            .PIX_W (PIX_W)
        ) u_ram (
            .clk     (clk),
            .rst_n   (reset),
            .we_i    (wr_accept && (wr_bank_q == 1'(b))),
            .waddr_i (wr_addr[IDX_W-1:0]),
            .wdata_i (wr_data[PIX_W-1:0]),
            .re_i    (rd_accept && rd_in_range && (rd_bank_q == 1'(b))),
            .raddr_i (rd_addr[IDX_W-1:0]),
            .rdata_o (rdata[b])
        );
    end

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign rd_valid  = rd_valid_q;
    assign rd_pixel  = rd_oor_q ? '0 : rdata[rd_sel_q];
    assign bank_full = {state_q[1] != BANK_EMPTY, state_q[0] != BANK_EMPTY};
    assign err_addr  = err_addr_q;
    assign err_drop  = err_drop_q;

endmodule
